delay_line_cfg: RTL

//  Parametrised, runtime-configurable delay pipe. Replaces the fixed-depth delay-line family.

---
 rtl/delay_line_cfg.sv | 81 ++++++++
 1 files changed

// File: rtl/delay_line_cfg.sv
// Runtime-configurable delay pipe: payload plus valid tag delayed by 0..MAX_DEPTH enabled cycles.
// Supports stall, valid flush, saturating delay load and a busy flag over the active stages.
module delay_line_cfg #(
   parameter int DATA_W    = 24,
   parameter int MAX_DEPTH = 16,
   parameter int DEF_DELAY = 1,
   parameter int DEL_W     = $clog2(MAX_DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              flush_i,
   input  logic              cfg_load_i,
   input  logic [DEL_W-1:0]  delay_sel_i,
   input  logic [DATA_W-1:0] data_in_i,
   input  logic              valid_in_i,
   output logic [DATA_W-1:0] data_out_o,
   output logic              valid_out_o,
   output logic [DEL_W-1:0]  cur_delay_o,
   output logic              busy_o
);

   localparam logic [DEL_W-1:0] MAX_SEL = DEL_W'(MAX_DEPTH);
   localparam logic [DEL_W-1:0] DEF_SEL = DEL_W'(DEF_DELAY);

   // index k holds stage k+1
   logic [DATA_W-1:0]    d_q [MAX_DEPTH];
   logic [DATA_W-1:0]    d_d [MAX_DEPTH];
   logic [MAX_DEPTH-1:0] v_q, v_d;
   logic [DEL_W-1:0]     cur_q, cur_d;
   logic                 tap_v;

   always_comb begin
      cur_d = cur_q;
      v_d   = v_q;
      d_d   = d_q;
      if (cfg_load_i) begin
         cur_d = (delay_sel_i > MAX_SEL) ? MAX_SEL : delay_sel_i;
         v_d   = '0;
      end else if (flush_i) begin
         v_d = '0;
      end else if (en_i) begin
         d_d[0] = data_in_i;
         v_d[0] = valid_in_i;
         for (int k = 1; k < MAX_DEPTH; k++) begin
            d_d[k] = d_q[k-1];
            v_d[k] = v_q[k-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < MAX_DEPTH; k++) d_q[k] <= '0;
         v_q   <= '0;
         cur_q <= DEF_SEL;
      end else begin
         d_q   <= d_d;
         v_q   <= v_d;
         cur_q <= cur_d;
      end
   end

   // A delay of zero falls through every tap compare and leaves the input as pass-through.
   always_comb begin
      data_out_o = data_in_i;
      tap_v      = valid_in_i;
      busy_o     = 1'b0;
      for (int k = 0; k < MAX_DEPTH; k++) begin
         if (cur_q == DEL_W'(k + 1)) begin
            data_out_o = d_q[k];
            tap_v      = v_q[k];
         end
         if (DEL_W'(k + 1) <= cur_q) busy_o = busy_o | v_q[k];
      end
   end

   assign valid_out_o = en_i & tap_v;
   assign cur_delay_o = cur_q;

endmodule
